// File: rtl/serial_sequencer.sv
// Control sequencer for a bit-serial ALU datapath.
// Accepts one 3-bit opcode at a time. ALU ops (ADD..MOV) run for WIDTH shift
// cycles and are followed by a single write/pc-advance cycle. NOP advances
// the PC in the acceptance cycle. HALT parks the sequencer until reset.
module serial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [2:0] opcode,
  output logic       instr_ready,
  output logic       shift,
  output logic [2:0] alu_func,
  output logic       carry_clr,
  output logic       carry_set,
  output logic       write,
  output logic       pc_incr,
  output logic       busy,
  output logic       halted
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_WRITE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       op_latched;

  // State, bit counter and latched opcode; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      op_latched <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            if (opcode == OP_HALT) begin
              state <= S_HALT;
            end else if (opcode != OP_NOP) begin
              op_latched <= opcode;
              bit_cnt    <= '0;
              state      <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          // Counter saturates on the last bit so it never wraps while executing.
          if (bit_cnt == LAST_BIT) begin
            state <= S_WRITE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          state <= S_IDLE;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from state; everything is forced low while reset is held.
  always_comb begin
    instr_ready = 1'b0;
    shift       = 1'b0;
    alu_func    = 3'd0;
    carry_clr   = 1'b0;
    carry_set   = 1'b0;
    write       = 1'b0;
    pc_incr     = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          instr_ready = 1'b1;
          pc_incr     = instr_valid && (opcode == OP_NOP);
        end
        S_EXEC: begin
          shift     = 1'b1;
          alu_func  = op_latched;
          busy      = 1'b1;
          carry_set = (bit_cnt == '0) && (op_latched == OP_SUB);
          carry_clr = (bit_cnt == '0) && (op_latched != OP_SUB);
        end
        S_WRITE: begin
          write   = 1'b1;
          pc_incr = 1'b1;
          busy    = 1'b1;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          instr_ready = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sequencer.sv
// Testbench for serial_sequencer (WIDTH=8): cycle-accurate reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_serial_sequencer;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [2:0] opcode;
  logic       instr_ready;
  logic       shift;
  logic [2:0] alu_func;
  logic       carry_clr;
  logic       carry_set;
  logic       write;
  logic       pc_incr;
  logic       busy;
  logic       halted;

  int n_cmp = 0;
  int n_err = 0;

  serial_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .instr_ready (instr_ready),
    .shift       (shift),
    .alu_func    (alu_func),
    .carry_clr   (carry_clr),
    .carry_set   (carry_set),
    .write       (write),
    .pc_incr     (pc_incr),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: phase counts cycles since an ALU op was accepted
  // (0 = free, 1..W = shift cycles, W+1 = write cycle).
  int         m_phase = 0;
  logic [2:0] m_op    = 3'd0;
  logic       m_halt  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_op    <= 3'd0;
      m_halt  <= 1'b0;
    end else if (m_halt) begin
      m_halt <= 1'b1;
    end else if (m_phase == 0) begin
      if (instr_valid && opcode == 3'd7) begin
        m_halt <= 1'b1;
      end else if (instr_valid && opcode != 3'd0) begin
        m_phase <= 1;
        m_op    <= opcode;
      end
    end else begin
      m_phase <= (m_phase == W + 1) ? 0 : m_phase + 1;
    end
  end

  always @(negedge clk) begin
    logic       e_rdy, e_sh, e_cc, e_cs, e_wr, e_pc, e_bz, e_hl;
    logic [2:0] e_fn;
    e_rdy = 0; e_sh = 0; e_cc = 0; e_cs = 0; e_wr = 0; e_pc = 0; e_bz = 0; e_hl = 0;
    e_fn  = 3'd0;
    if (!rst) begin
      if (m_halt) begin
        e_hl = 1;
      end else if (m_phase == 0) begin
        e_rdy = 1;
        e_pc  = instr_valid && (opcode == 3'd0);
      end else if (m_phase <= W) begin
        e_sh = 1;
        e_fn = m_op;
        e_bz = 1;
        e_cs = (m_phase == 1) && (m_op == 3'd2);
        e_cc = (m_phase == 1) && (m_op != 3'd2);
      end else begin
        e_wr = 1;
        e_pc = 1;
        e_bz = 1;
      end
    end
    chk("mon_instr_ready", 8'(instr_ready), 8'(e_rdy));
    chk("mon_shift",       8'(shift),       8'(e_sh));
    chk("mon_alu_func",    8'(alu_func),    8'(e_fn));
    chk("mon_carry_clr",   8'(carry_clr),   8'(e_cc));
    chk("mon_carry_set",   8'(carry_set),   8'(e_cs));
    chk("mon_write",       8'(write),       8'(e_wr));
    chk("mon_pc_incr",     8'(pc_incr),     8'(e_pc));
    chk("mon_busy",        8'(busy),        8'(e_bz));
    chk("mon_halted",      8'(halted),      8'(e_hl));
  end

  // Apply one cycle of inputs just after the rising edge; return at the
  // following falling edge so outputs for that cycle can be inspected.
  task automatic cyc(input logic r, input logic v, input logic [2:0] op);
    @(posedge clk);
    #1;
    rst = r;
    instr_valid = v;
    opcode = op;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    opcode = 3'd0;

    // Reset
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("rst_ready", 8'(instr_ready), 8'd0);
    chk("rst_nop_pc", 8'(pc_incr), 8'd0);
    cyc(0, 0, 0);
    chk("idle_ready", 8'(instr_ready), 8'd1);
    chk("idle_busy", 8'(busy), 8'd0);

    // ADD
    cyc(0, 1, 3'd1);
    chk("add_accept_ready", 8'(instr_ready), 8'd1);
    for (int k = 1; k <= W; k++) begin
      cyc(0, 0, 0);
      chk("add_shift", 8'(shift), 8'd1);
      chk("add_func", 8'(alu_func), 8'd1);
      chk("add_cclr", 8'(carry_clr), 8'(k == 1));
      chk("add_write_early", 8'(write), 8'd0);
    end
    cyc(0, 0, 0);
    chk("add_write", 8'(write), 8'd1);
    chk("add_pc", 8'(pc_incr), 8'd1);
    chk("add_wr_shift", 8'(shift), 8'd0);
    chk("add_wr_func", 8'(alu_func), 8'd0);
    cyc(0, 0, 0);
    chk("add_ready_t10", 8'(instr_ready), 8'd1);

    // SUB
    cyc(0, 1, 3'd2);
    for (int k = 1; k <= W; k++) begin
      cyc(0, 0, 0);
      chk("sub_cset", 8'(carry_set), 8'(k == 1));
      chk("sub_cclr", 8'(carry_clr), 8'd0);
      chk("sub_func", 8'(alu_func), 8'd2);
    end
    cyc(0, 0, 0);
    chk("sub_write", 8'(write), 8'd1);

    // Three NOPs back to back
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 3'd0);
      chk("nop_pc", 8'(pc_incr), 8'd1);
      chk("nop_busy", 8'(busy), 8'd0);
      chk("nop_shift", 8'(shift), 8'd0);
    end

    // ADD with opcode switched to XOR while executing
    cyc(0, 1, 3'd1);
    for (int k = 1; k <= W; k++) begin
      cyc(0, 1, 3'd5);
      chk("addx_func", 8'(alu_func), 8'd1);
    end
    cyc(0, 1, 3'd5);
    chk("addx_write", 8'(write), 8'd1);
    chk("addx_ready_wr", 8'(instr_ready), 8'd0);
    cyc(0, 1, 3'd5);
    chk("xor_accept_ready", 8'(instr_ready), 8'd1);
    cyc(0, 0, 0);
    chk("xor_func", 8'(alu_func), 8'd5);
    chk("xor_cclr", 8'(carry_clr), 8'd1);
    for (int k = 0; k < W + 1; k++) cyc(0, 0, 0);
    chk("xor_done_ready", 8'(instr_ready), 8'd1);

    // Reset while executing bit 4 of an AND
    cyc(0, 1, 3'd3);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("abort_shift", 8'(shift), 8'd0);
    cyc(0, 0, 0);
    chk("abort_ready", 8'(instr_ready), 8'd1);
    chk("abort_busy", 8'(busy), 8'd0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0);
      chk("abort_no_write", 8'(write), 8'd0);
      chk("abort_no_pc", 8'(pc_incr), 8'd0);
    end

    // HALT
    cyc(0, 1, 3'd7);
    chk("halt_no_pc", 8'(pc_incr), 8'd0);
    cyc(0, 0, 0);
    chk("halt_flag", 8'(halted), 8'd1);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, 3'(k % 7));
      chk("halt_stuck", 8'(halted), 8'd1);
      chk("halt_ready", 8'(instr_ready), 8'd0);
      chk("halt_pc", 8'(pc_incr), 8'd0);
    end
    cyc(1, 0, 0);
    chk("halt_rst", 8'(halted), 8'd0);
    cyc(0, 0, 0);
    chk("halt_exit_ready", 8'(instr_ready), 8'd1);
    chk("halt_exit_flag", 8'(halted), 8'd0);

    // Mixed stream checked by the reference model
    for (int k = 0; k < 300; k++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
          3'($urandom_range(0, 6)));
    end
    cyc(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
